// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the multicycle LEGv8 control FSM.
// The optional CBNZ decode is enabled by defining LEGV8_CBNZ_EN (see legv8_multicycle_ctrl).
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, ERROR
  } state_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_HI = 8'b10110101;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg2loc;
    logic       pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       error;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c             = '0;
    c.alu_control = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/legv8_alu_op_decoder.sv
// R-type opcode to 4-bit ALU control; anything not recognised defaults to ADD.
module legv8_alu_op_decoder
  import legv8_ctrl_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic [OP_W-1:0] op,
  output logic [3:0]      alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (op)
      OP_SUB:  alu_control = ALU_SUB;
      OP_AND:  alu_control = ALU_AND;
      OP_ORR:  alu_control = ALU_ORR;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM with memory-wait timeout and sticky error.
// Define LEGV8_CBNZ_EN to decode CBNZ as a branch taken on ~zero.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int OP_W        = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [3:0]      alu_control,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            reg2loc,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            error
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [3:0]       r_alu;
  logic             strobe_on, mem_done, fetch_done, branch_take, is_r, is_mem;

  legv8_alu_op_decoder #(.OP_W(OP_W)) u_alu_dec (
    .op          (op),
    .alu_control (r_alu)
  );

  // Handshake is qualified by the registered strobe, so the strobe-less
  // FETCH cycle right after reset neither completes nor counts as a wait.
  always_comb begin
    strobe_on  = ctrl_q.mem_read | ctrl_q.mem_write;
    mem_done   = strobe_on & mem_ready;
    fetch_done = (state_q == FETCH) & mem_done;
`ifdef LEGV8_CBNZ_EN
    branch_take = (op[OP_W-1 -: 8] == OP_CBNZ_HI) ? ~zero : zero;
`else
    branch_take = zero;
`endif
    ir_write = fetch_done;
    pc_write = fetch_done | ((state_q == BRANCH) & branch_take);
    is_r     = (op == OP_ADD) | (op == OP_SUB) | (op == OP_AND) | (op == OP_ORR);
    is_mem   = (op == OP_LDUR) | (op == OP_STUR);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH, MEM_RD, MEM_WR: begin
        if (mem_done) begin
          if (state_q == FETCH)       state_d = DECODE;
          else if (state_q == MEM_RD) state_d = WB_MEM;
          else                        state_d = FETCH;
        end else if (strobe_on) begin
          if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) state_d = ERROR;
          else                                  cnt_d   = cnt_q + 1'b1;
        end
      end
      DECODE: begin
        if (is_r)                                   state_d = EXEC_R;
        else if (is_mem)                            state_d = ADDR;
        else if (op[OP_W-1 -: 8] == OP_CBZ_HI)      state_d = BRANCH;
`ifdef LEGV8_CBNZ_EN
        else if (op[OP_W-1 -: 8] == OP_CBNZ_HI)     state_d = BRANCH;
`endif
        else                                        state_d = ERROR;
      end
      EXEC_R:  state_d = WB_R;
      WB_R:    state_d = FETCH;
      ADDR:    state_d = (op == OP_STUR) ? MEM_WR : MEM_RD;
      WB_MEM:  state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_comb begin
    ctrl_d = ctrl_idle();
    case (state_d)
      FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
      end
      DECODE: ctrl_d.alu_src_b = SRCB_IMM_SH2;
      EXEC_R: begin
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_src_b   = SRCB_REG;
        ctrl_d.alu_control = r_alu;
      end
      WB_R: ctrl_d.reg_write = 1'b1;
      ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.reg2loc   = (op == OP_STUR);
      end
      MEM_RD: ctrl_d.mem_read = 1'b1;
      WB_MEM: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.reg2loc   = 1'b1;
      end
      BRANCH: begin
        ctrl_d.reg2loc     = 1'b1;
        ctrl_d.alu_control = ALU_PASSB;
        ctrl_d.alu_src_b   = SRCB_REG;
        ctrl_d.pc_src      = 1'b1;
      end
      ERROR:   ctrl_d.error = 1'b1;
      default: ctrl_d = ctrl_idle();
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      ctrl_q  <= ctrl_idle();
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign alu_control = ctrl_q.alu_control;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign reg2loc     = ctrl_q.reg2loc;
  assign pc_src      = ctrl_q.pc_src;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign error       = ctrl_q.error;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench: per-instruction phase model fills an expected per-cycle output queue,
// a memory responder plays back planned wait counts, and a monitor pops and compares.
`timescale 1ns/1ps
module tb_legv8_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 16;
`ifdef LEGV8_CBNZ_EN
  localparam bit CBNZ_EN = 1'b1;
`else
  localparam bit CBNZ_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [10:0] op = '0;
  logic [3:0] alu_control;
  logic [1:0] alu_src_b;
  logic alu_src_a, reg2loc, ir_write, pc_write, pc_src, mem_read, mem_write;
  logic mem_to_reg, reg_write, error;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .OP_W(11)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg2loc(reg2loc), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .error(error)
  );

  typedef struct packed {
    logic [3:0] alu; logic sa; logic [1:0] sb;
    logic r2l, irw, pcw, pcs, mr, mw, m2r, rw, err;
  } vec_t;
  typedef struct { int w; logic [10:0] op; logic z; bit fetch; } acc_t;

  vec_t  exp_q[$];
  string tag_q[$];
  acc_t  acc_q[$];
  int    checks = 0, errors = 0;
  bit    arm = 1'b0, dead = 1'b0;

  function automatic vec_t base();
    vec_t v = '0;
    v.alu = 4'b0010;
    return v;
  endfunction

  // 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 CBNZ, 5 illegal
  function automatic int classify(input logic [10:0] o);
    logic [7:0] hi;
    hi = o[10:3];
    if (o == 11'b10001011000 || o == 11'b11001011000 ||
        o == 11'b10001010000 || o == 11'b10101010000) return 0;
    if (o == 11'b11111000010) return 1;
    if (o == 11'b11111000000) return 2;
    if (hi == 8'b10110100) return 3;
    if (hi == 8'b10110101 && CBNZ_EN) return 4;
    return 5;
  endfunction

  function automatic logic [3:0] r_alu(input logic [10:0] o);
    if (o == 11'b11001011000) return 4'b0110;
    if (o == 11'b10001010000) return 4'b0000;
    if (o == 11'b10101010000) return 4'b0001;
    return 4'b0010;
  endfunction

  task automatic push(input vec_t v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic go_error();
    vec_t v = base();
    v.err = 1'b1;
    for (int i = 0; i < 3; i++) push(v, "error");
    dead = 1'b1;
  endtask

  // One memory-waiting state: ready arrives after w low cycles, or timeout after MEM_TIMEOUT.
  task automatic mem_phase(input vec_t vb, input int w, input bit is_fetch, input string t);
    vec_t v;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      v = vb;
      if (i == w && is_fetch) begin v.irw = 1'b1; v.pcw = 1'b1; end
      push(v, t);
      if (i == w) return;
    end
    go_error();
  endtask

  task automatic add_instr(input logic [10:0] o, input logic z, input int wf, input int wm);
    vec_t v;
    int k;
    if (dead) return;
    acc_q.push_back('{wf, o, z, 1'b1});
    v = base(); v.mr = 1'b1; v.sb = 2'b01;
    mem_phase(v, wf, 1'b1, "fetch");
    if (dead) return;
    v = base(); v.sb = 2'b11;
    push(v, "decode");
    k = classify(o);
    case (k)
      0: begin
        v = base(); v.sa = 1'b1; v.sb = 2'b00; v.alu = r_alu(o);
        push(v, "exec_r");
        v = base(); v.rw = 1'b1;
        push(v, "wb_r");
      end
      1, 2: begin
        acc_q.push_back('{wm, o, z, 1'b0});
        v = base(); v.sa = 1'b1; v.sb = 2'b10; v.r2l = (k == 2);
        push(v, "addr");
        v = base();
        if (k == 1) v.mr = 1'b1; else begin v.mw = 1'b1; v.r2l = 1'b1; end
        mem_phase(v, wm, 1'b0, (k == 1) ? "mem_rd" : "mem_wr");
        if (!dead && k == 1) begin
          v = base(); v.rw = 1'b1; v.m2r = 1'b1;
          push(v, "wb_mem");
        end
      end
      3, 4: begin
        v = base(); v.r2l = 1'b1; v.alu = 4'b0111; v.sb = 2'b00; v.pcs = 1'b1;
        v.pcw = (k == 4) ? ~z : z;
        push(v, "branch");
      end
      default: go_error();
    endcase
  endtask

  // Memory responder: plays back planned waits; noise on mem_ready when no strobe is up.
  int   cur = -1;
  bit   pend_f = 1'b0;
  logic [10:0] pend_op = '0;
  logic pend_z = 1'b0;
  always @(posedge clk) begin : responder
    acc_t a;
    #1;
    if (!reset || !(mem_read || mem_write)) begin
      cur = -1;
      pend_f = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
    end else begin
      if (cur < 0) begin
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          cur = a.w; pend_f = a.fetch; pend_op = a.op; pend_z = a.z;
        end else begin
          cur = 100000; pend_f = 1'b0;
        end
      end
      if (cur == 0) begin
        mem_ready = 1'b1;
        cur = -1;
        if (pend_f) begin op = pend_op; zero = pend_z; end
      end else begin
        mem_ready = 1'b0;
        cur--;
      end
    end
  end

  always @(negedge clk) begin : monitor
    vec_t e, a;
    string t;
    if (arm && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {alu_control, alu_src_a, alu_src_b, reg2loc, ir_write, pc_write, pc_src,
           mem_read, mem_write, mem_to_reg, reg_write, error};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", t, a, e);
      end
    end
  end

  task automatic start_prog();
    @(posedge clk); #1;
    reset = 1'b0; arm = 1'b0; dead = 1'b0;
    exp_q.delete(); tag_q.delete(); acc_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    push(base(), "reset");
  endtask

  task automatic go();
    int guard = 0;
    reset = 1'b1;
    arm = 1'b1;
    while (exp_q.size() > 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    arm = 1'b0;
  endtask

  function automatic logic [10:0] rand_op(input int r);
    logic [10:0] o;
    case (r)
      0: o = 11'b10001011000;
      1: o = 11'b11001011000;
      2: o = 11'b10001010000;
      3: o = 11'b10101010000;
      4: o = 11'b11111000010;
      5: o = 11'b11111000000;
      6: o = {8'b10110100, 3'($urandom)};
      7: o = {8'b10110101, 3'($urandom)};
      8: o = 11'($urandom);
      default: o = 11'b11111111111;
    endcase
    return o;
  endfunction

  initial begin
    start_prog();
    add_instr(11'b10001011000, 1'b0, 0, 0);
    add_instr(11'b11001011000, 1'b0, 1, 0);
    add_instr(11'b10001010000, 1'b0, 0, 0);
    add_instr(11'b10101010000, 1'b0, 2, 0);
    add_instr(11'b11111000010, 1'b0, 0, 3);
    add_instr(11'b10110100101, 1'b1, 0, 0);
    add_instr(11'b10110100000, 1'b0, 1, 0);
    add_instr(11'b11111000000, 1'b0, 0, MEM_TIMEOUT - 1);
    add_instr(11'b11111000000, 1'b0, 0, 0);
    go();

    start_prog();
    add_instr(11'b11111000000, 1'b0, 0, 40);
    go();

    start_prog();
    add_instr(11'b10001011000, 1'b0, 0, 0);
    add_instr(11'b11111111111, 1'b0, 0, 0);
    go();

    start_prog();
    add_instr(11'b10110101011, 1'b0, 0, 0);
    add_instr(11'b10001011000, 1'b0, 0, 0);
    go();

    for (int p = 0; p < 30; p++) begin
      int n;
      start_prog();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        int r, wm;
        r  = (i == n - 1) ? $urandom_range(0, 9) : $urandom_range(0, 7);
        wm = ($urandom_range(0, 11) == 0) ? (($urandom_range(0, 1) == 1) ? 20 : MEM_TIMEOUT - 1)
                                          : $urandom_range(0, 4);
        add_instr(rand_op(r), 1'($urandom), $urandom_range(0, 3), wm);
      end
      go();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
